// File: rtl/currctrl_ram_pkg.sv
// Shared constants and types for the current-control RAM port-2 logic.
package currctrl_ram_pkg;

    localparam int RAM_DEPTH  = 256;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;
    localparam int RD_LATENCY = 2;   // transfer edge to readdata: command flop + RAM address flop

    // Requester index width; covers up to four requesters.
    localparam int ID_W = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // One stage of the read issue pipeline: which requester owns the read in flight.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/currctrl_ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request at or after ptr.
module rr_pick
    import currctrl_ram_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt
);

    logic found;

    // Scan requesters in rotated order starting at ptr; first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (((int'(ptr) + i) % N) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/currctrl_ram_port_arbiter.sv
// Port-2 arbiter for the 256 x 32 current-control RAM: round-robin with burst
// lock, registered RAM command, and read data returned to the issuing requester.
// Optional starvation preemption is compiled in with CURRCTRL_ARB_STARVE_EN.
module currctrl_ram_port_arbiter
    import currctrl_ram_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          lock_i,
    input  logic [N_REQ-1:0]          wr_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ*DATA_W/8-1:0] be_i,
    input  logic [N_REQ*DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [ADDR_W-1:0]         ram_address,
    output logic [DATA_W/8-1:0]       ram_byteenable,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [DATA_W-1:0]         ram_writedata,
    output logic                      ram_clken,
    input  logic [DATA_W-1:0]         ram_readdata,
    output logic                      starve_o
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        state;
    logic [N_REQ-1:0]  owner_oh;
    logic [7:0]        beat_cnt;
    logic [ID_W-1:0]   ptr;
    logic [N_REQ-1:0]  rr_gnt;
    logic              any_xfer;
    logic              owner_req;
    logic              owner_lock;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   next_ptr;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic [N_REQ-1:0]  rvalid_d;
    rd_tag_t           tag_q [RD_LATENCY];

`ifdef CURRCTRL_ARB_STARVE_EN
    logic [N_REQ-1:0][15:0] wait_cnt;
    logic [N_REQ-1:0]       starve_vec;
    logic [N_REQ-1:0]       starve_pick;
    logic [N_REQ-1:0]       force_q;
    logic                   starve_hit;
    logic [ID_W-1:0]        ptr_eff;
`endif

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .req (req_i),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    // Grant: the owner alone while locked, round-robin otherwise, forced winner after preemption.
    always_comb begin
        gnt_o = '0;
        if (state == LOCKED) gnt_o = owner_oh & req_i;
        else                 gnt_o = rr_gnt;
`ifdef CURRCTRL_ARB_STARVE_EN
        if (|force_q) gnt_o = force_q & req_i;
`endif
    end

    // Decode the granted requester's command fields and index.
    always_comb begin
        any_xfer   = |gnt_o;
        owner_req  = |(owner_oh & req_i);
        owner_lock = |(owner_oh & lock_i);
        gnt_id     = '0;
        sel_wr     = 1'b0;
        sel_addr   = '0;
        sel_be     = '0;
        sel_wdata  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                gnt_id    = ID_W'(k);
                sel_wr    = wr_i[k];
                sel_addr  = addr_i[k*ADDR_W +: ADDR_W];
                sel_be    = be_i[k*BE_W +: BE_W];
                sel_wdata = wdata_i[k*DATA_W +: DATA_W];
            end
        end
        next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    // Arbitration FSM: round-robin pointer, lock owner and burst beat count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner_oh <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (any_xfer) ptr <= next_ptr;
            case (state)
                IDLE: begin
                    if (any_xfer && |(gnt_o & lock_i) && (MAX_BURST > 1)) begin
                        state    <= LOCKED;
                        owner_oh <= gnt_o;
                        beat_cnt <= 8'd1;
                    end
                end
                LOCKED: begin
                    if (!owner_req) begin
                        state    <= IDLE;
                        owner_oh <= '0;
                        beat_cnt <= '0;
                    end else if (any_xfer) begin
                        if (!owner_lock || (int'(beat_cnt) >= MAX_BURST - 1)) begin
                            state    <= IDLE;
                            owner_oh <= '0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef CURRCTRL_ARB_STARVE_EN
            // Preemption overrides whatever the lock logic decided this edge.
            if (starve_hit) begin
                state    <= IDLE;
                owner_oh <= '0;
                beat_cnt <= '0;
            end
`endif
        end
    end

    // Registered RAM command; address and data hold when idle to avoid toggling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_writedata  <= '0;
            ram_clken      <= 1'b0;
        end else begin
            ram_clken      <= 1'b1;
            ram_chipselect <= any_xfer;
            ram_write      <= any_xfer & sel_wr;
            if (any_xfer) begin
                ram_address    <= sel_addr;
                ram_byteenable <= sel_be;
                ram_writedata  <= sel_wdata;
            end
        end
    end

    // Read tag pipeline matched to the RAM latency, then registered return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the tag array is reset because its valid bits must drop an in-flight read.
            for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else begin
            tag_q[0] <= rd_tag_t'{valid: any_xfer & ~sel_wr, id: gnt_id};
            for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            rvalid_o <= rvalid_d;
            if (tag_q[RD_LATENCY-1].valid) rdata_o <= ram_readdata;
        end
    end

    // Steer the returning read to its requester.
    always_comb begin
        rvalid_d = '0;
        for (int k = 0; k < N_REQ; k++)
            rvalid_d[k] = tag_q[RD_LATENCY-1].valid && (tag_q[RD_LATENCY-1].id == ID_W'(k));
    end

`ifdef CURRCTRL_ARB_STARVE_EN
    // A waiter about to reach the limit while someone else holds the lock is starving.
    always_comb begin
        starve_vec = '0;
        for (int k = 0; k < N_REQ; k++)
            starve_vec[k] = (state == LOCKED) && !owner_oh[k] && req_i[k] && !gnt_o[k]
                            && (wait_cnt[k] == 16'(STARVE_LIMIT - 1));
        starve_hit = |starve_vec;
        ptr_eff    = any_xfer ? next_ptr : ptr;
    end

    rr_pick #(.N(N_REQ)) u_starve_pick (
        .req (starve_vec),
        .ptr (ptr_eff),
        .gnt (starve_pick)
    );

    // Per-requester wait counters and the one-cycle forced grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            force_q  <= '0;
            starve_o <= 1'b0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt_o[k])
                    wait_cnt[k] <= '0;
                else if (req_i[k] && (wait_cnt[k] < 16'(STARVE_LIMIT)))
                    wait_cnt[k] <= wait_cnt[k] + 16'd1;
            end
            force_q  <= starve_hit ? starve_pick : '0;
            starve_o <= starve_hit;
        end
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
    assign starve_o          = 1'b0;
`endif

endmodule

// File: tb/tb_currctrl_ram_port_arbiter.sv
// Self-checking bench for currctrl_ram_port_arbiter with a behavioural RAM and arbiter model.
module tb_currctrl_ram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 4;
`ifdef CURRCTRL_ARB_STARVE_EN
    localparam int MAXB = 255;
    localparam int LIM  = 4;
`else
    localparam int MAXB = 8;
    localparam int LIM  = 32;
`endif

    typedef struct {
        bit        pend;
        bit        lock;
        bit        wr;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } rd_t;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_i, lock_i, wr_i;
    logic [N*AW-1:0] addr_i;
    logic [N*BW-1:0] be_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic [AW-1:0]   ram_address;
    logic [BW-1:0]   ram_byteenable;
    logic            ram_chipselect, ram_write, ram_clken, starve_o;
    logic [DW-1:0]   ram_writedata, ram_readdata;

    currctrl_ram_port_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req_i), .lock_i(lock_i), .wr_i(wr_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .ram_address(ram_address),
        .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .starve_o(starve_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM (port 2, registered address, unregistered q) ----
    logic [31:0] mem [256];
    logic [31:0] rd_q;
    bit          preload;

    function automatic logic [31:0] init_val(logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : 32'hAAAAAAAA;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (ram_chipselect && ram_clken) begin
            if (ram_write) mem[ram_address] <= merge(mem[ram_address], ram_writedata, ram_byteenable);
            else           rd_q <= mem[ram_address];
        end
    end
    assign ram_readdata = rd_q;

    // ---------------- bench state and reference model ----------------
    cmd_t        cmd [N];
    rd_t         rq [$];
    logic [31:0] shadow [256];
    int          m_owner, m_beats, m_ptr, m_force;
    int          m_wait [N];
    bit          m_px;
    cmd_t        m_pc;
    int          cyc, gid, total, bad;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(int k, bit p, bit l, bit w, logic [7:0] a, logic [3:0] b, logic [31:0] d);
        cmd[k].pend = p; cmd[k].lock = l; cmd[k].wr = w;
        cmd[k].addr = a; cmd[k].be = b; cmd[k].data = d;
    endtask

    task automatic clear_cmds();
        for (int k = 0; k < N; k++) set_cmd(k, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_i[k]             = cmd[k].pend;
            lock_i[k]            = cmd[k].lock;
            wr_i[k]              = cmd[k].wr;
            addr_i[k*AW +: AW]   = cmd[k].addr;
            be_i[k*BW +: BW]     = cmd[k].be;
            wdata_i[k*DW +: DW]  = cmd[k].data;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_ptr = 0; m_force = -1; m_px = 1'b0;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
        rq.delete();
    endtask

    // Drive current commands, then at the falling edge compare everything the
    // model predicts for this cycle and advance the model to the next cycle.
    task automatic sample();
        int          e, pk, old_owner, new_ptr;
        logic [N-1:0] eg, er;
        drive();
        @(negedge clk);
        cyc++;
        e = -1;
        if (m_force >= 0)      e = cmd[m_force].pend ? m_force : -1;
        else if (m_owner >= 0) e = cmd[m_owner].pend ? m_owner : -1;
        else for (int i = 0; i < N; i++) if (e < 0 && cmd[(m_ptr + i) % N].pend) e = (m_ptr + i) % N;
        eg = '0;
        if (e >= 0) eg[e] = 1'b1;
        check("gnt", gnt_o, eg);
        check("ram_cs", ram_chipselect, m_px);
        if (m_px) begin
            check("ram_wr", ram_write, m_pc.wr);
            check("ram_addr", ram_address, m_pc.addr);
            check("ram_be", ram_byteenable, m_pc.be);
            check("ram_wdata", ram_writedata, m_pc.data);
        end
        er = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            er[rq[0].id] = 1'b1;
            check("rdata", rdata_o, rq[0].data);
            void'(rq.pop_front());
        end
        check("rvalid", rvalid_o, er);
        check("starve", starve_o, m_force >= 0);

        // ---- advance the model ----
        m_px = (e >= 0);
        if (e >= 0) begin
            m_pc = cmd[e];
            if (cmd[e].wr) shadow[cmd[e].addr] = merge(shadow[cmd[e].addr], cmd[e].data, cmd[e].be);
            else           rq.push_back('{id: e, data: shadow[cmd[e].addr], due: cyc + 3});
        end
        new_ptr   = (e >= 0) ? (e + 1) % N : m_ptr;
        old_owner = m_owner;
        pk        = -1;
`ifdef CURRCTRL_ARB_STARVE_EN
        for (int i = 0; i < N; i++) begin
            int k;
            k = (new_ptr + i) % N;
            if (pk < 0 && old_owner >= 0 && k != old_owner && cmd[k].pend && e != k && m_wait[k] == LIM - 1)
                pk = k;
        end
        for (int k = 0; k < N; k++) begin
            if (e == k) m_wait[k] = 0;
            else if (cmd[k].pend && m_wait[k] < LIM) m_wait[k]++;
        end
`endif
        if (old_owner < 0) begin
            if (e >= 0 && cmd[e].lock && MAXB > 1) begin m_owner = e; m_beats = 1; end
        end else if (!cmd[old_owner].pend) begin
            m_owner = -1;
        end else if (e >= 0) begin
            m_beats++;
            if (!cmd[old_owner].lock || m_beats >= MAXB) m_owner = -1;
        end
        if (pk >= 0) m_owner = -1;
        m_force = pk;
        m_ptr   = new_ptr;
        gid     = e;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        clear_cmds();
        for (int i = 0; i < n; i++) begin sample(); advance(); end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_cmds();
        drive();
        @(negedge clk);
        check("rst_cmd", {ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata}, 64'h0);
        check("rst_rsp", {rvalid_o, rdata_o, starve_o, ram_clken, gnt_o}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        advance();
        check("clken_on", ram_clken, 1'b1);
    endtask

    initial begin
        logic [N-1:0] burst_seq [13];
        int           b0;
        total = 0; bad = 0; cyc = 0; gid = -1;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
        clear_cmds();
        drive();
        reset_n = 1'b0;
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        do_reset();

        // ---- single read of the preloaded word ----
        set_cmd(0, 1'b1, 1'b0, 1'b0, 8'h10, 4'hF, 32'h0);
        sample();
        check("rd_gnt", gnt_o, 2'b01);
        advance();
        clear_cmds();
        sample();
        check("rd_cs", ram_chipselect, 1'b1);
        check("rd_addr", ram_address, 8'h10);
        advance();
        sample(); advance();
        sample();
        check("rd_rvalid", rvalid_o, 2'b01);
        check("rd_data", rdata_o, 32'hDEADBEEF);
        advance();

        // ---- contention without lock alternates from requester 0 ----
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_cmd(0, 1'b1, 1'b0, 1'b0, 8'(c), 4'hF, 32'h0);
            set_cmd(1, 1'b1, 1'b0, 1'b0, 8'(c + 32), 4'hF, 32'h0);
            sample();
            check("contend_gnt", gnt_o, (c % 2 == 0) ? 2'b01 : 2'b10);
            advance();
        end
        idle_cycles(4);

`ifndef CURRCTRL_ARB_STARVE_EN
        // ---- burst lock bounded by MAX_BURST ----
        do_reset();
        burst_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                      2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        b0 = 0;
        set_cmd(1, 1'b1, 1'b0, 1'b1, 8'h80, 4'hF, 32'h0BADF00D);
        for (int c = 0; c < 13; c++) begin
            set_cmd(0, b0 < 12, 1'b1, 1'b1, 8'(8'h40 + b0), 4'hF, 32'(c));
            sample();
            check("burst_gnt", gnt_o, burst_seq[c]);
            if (gid == 0) b0++;
            if (gid == 1) cmd[1].pend = 1'b0;
            advance();
        end
        check("burst_beats", b0, 12);
        idle_cycles(2);
`else
        // ---- starvation preemption of a long lock ----
        do_reset();
        set_cmd(1, 1'b1, 1'b0, 1'b0, 8'h22, 4'hF, 32'h0);
        for (int c = 0; c < 6; c++) begin
            set_cmd(0, 1'b1, 1'b1, 1'b0, 8'(c), 4'hF, 32'h0);
            sample();
            check("starve_pulse", starve_o, c == 4);
            if (c == 4) check("starve_gnt", gnt_o, 2'b10);
            if (gid == 1) cmd[1].pend = 1'b0;
            advance();
        end
        idle_cycles(4);
`endif

        // ---- partial write then read back at the top address ----
        clear_cmds();
        set_cmd(0, 1'b1, 1'b0, 1'b1, 8'hFF, 4'b0011, 32'h12345678);
        sample(); advance();
        set_cmd(0, 1'b1, 1'b0, 1'b0, 8'hFF, 4'hF, 32'h0);
        sample(); advance();
        clear_cmds();
        sample(); advance();
        sample(); advance();
        sample();
        check("wr_rd_valid", rvalid_o, 2'b01);
        check("wr_rd_data", rdata_o, 32'hAAAA5678);
        advance();

        // ---- reset while a read is in flight ----
        set_cmd(1, 1'b1, 1'b0, 1'b0, 8'h10, 4'hF, 32'h0);
        sample();
        check("mid_gnt", gnt_o, 2'b10);
        advance();
        do_reset();
        clear_cmds();
        for (int c = 0; c < 4; c++) begin
            sample();
            check("mid_no_rvalid", rvalid_o, 2'b00);
            advance();
        end
        set_cmd(0, 1'b1, 1'b0, 1'b0, 8'h01, 4'hF, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 1'b0, 8'h02, 4'hF, 32'h0);
        sample();
        check("mid_first_gnt", gnt_o, 2'b01);
        if (gid >= 0) cmd[gid].pend = 1'b0;
        advance();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!cmd[k].pend && $urandom_range(0, 2) == 0)
                    set_cmd(k, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom);
            end
            sample();
            if (gid >= 0) cmd[gid].pend = 1'b0;
            advance();
        end
        idle_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
